// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch pipeline.
package pipe_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } fetch_state_e;

    // Redirect targets are word aligned; the low two bits are ignored.
    function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] addr);
        return {addr[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry skid buffer holding a fetched word while IF/ID is stalled.
module fetch_skid_reg
    import pipe_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic [INSTR_W-1:0] i_data,
    output logic [INSTR_W-1:0] o_data,
    output logic               o_valid
);

    logic [INSTR_W-1:0] r_data;
    logic               r_valid;

    // Clear wins so a redirect can never leave a stale word behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, handles redirects, drives the
// instruction memory port and fills the IF/ID register.
module instr_fetch_unit
    import pipe_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [INSTR_W-1:0] NOP      = NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               branch,
    input  logic [INSTR_W-1:0] branchPCo,
    input  logic               stall,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [INSTR_W-1:0] if_pc4
);

    fetch_state_e       r_state,    w_state_nxt;
    logic [INSTR_W-1:0] r_pc,       w_pc_nxt;
    logic [INSTR_W-1:0] r_redir_pc, w_redir_nxt;
    logic               r_if_valid, w_if_valid_nxt;
    logic [INSTR_W-1:0] r_if_instr, w_if_instr_nxt;
    logic [INSTR_W-1:0] r_if_pc4,   w_if_pc4_nxt;

    logic               w_skid_load;
    logic               w_skid_clear;
    logic [INSTR_W-1:0] w_skid_data;
    logic               w_skid_valid;
    logic [INSTR_W-1:0] w_pc_plus4;
    logic [INSTR_W-1:0] w_target;

    assign w_pc_plus4 = r_pc + INSTR_W'(4);
    assign w_target   = align_pc(branchPCo);

    fetch_skid_reg u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (imem_rdata),
        .o_data  (w_skid_data),
        .o_valid (w_skid_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_redir_pc <= '0;
            r_if_valid <= 1'b0;
            r_if_instr <= NOP;
            r_if_pc4   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_redir_pc <= w_redir_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_if_pc4   <= w_if_pc4_nxt;
        end
    end

    // Next-state logic; a redirect always beats stall and kills IF/ID.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_redir_nxt    = r_redir_pc;
        w_if_valid_nxt = r_if_valid;
        w_if_instr_nxt = r_if_instr;
        w_if_pc4_nxt   = r_if_pc4;
        w_skid_load    = 1'b0;
        w_skid_clear   = 1'b0;

        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
                if (branch) begin
                    w_pc_nxt = w_target;
                end
            end

            FETCH: begin
                if (branch) begin
                    w_if_valid_nxt = 1'b0;
                    if (imem_ready) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_redir_nxt = w_target;
                        w_state_nxt = DISCARD;
                    end
                end else if (imem_ready) begin
                    if (!stall) begin
                        w_if_valid_nxt = 1'b1;
                        w_if_instr_nxt = imem_rdata;
                        w_if_pc4_nxt   = w_pc_plus4;
                        w_pc_nxt       = w_pc_plus4;
                    end else begin
                        w_skid_load = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end else if (!stall) begin
                    w_if_valid_nxt = 1'b0;
                end
            end

            // Address stays put until the stale response drains.
            DISCARD: begin
                w_if_valid_nxt = 1'b0;
                if (branch) begin
                    w_redir_nxt = w_target;
                end
                if (imem_ready) begin
                    w_pc_nxt    = branch ? w_target : r_redir_pc;
                    w_state_nxt = FETCH;
                end
            end

            HOLD: begin
                if (branch) begin
                    w_skid_clear   = 1'b1;
                    w_if_valid_nxt = 1'b0;
                    w_pc_nxt       = w_target;
                    w_state_nxt    = FETCH;
                end else if (!stall && w_skid_valid) begin
                    w_skid_clear   = 1'b1;
                    w_if_valid_nxt = 1'b1;
                    w_if_instr_nxt = w_skid_data;
                    w_if_pc4_nxt   = w_pc_plus4;
                    w_pc_nxt       = w_pc_plus4;
                    w_state_nxt    = FETCH;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign imem_req  = (r_state == FETCH) || (r_state == DISCARD);
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc4    = r_if_pc4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios plus random
// traffic checked against a behavioural model of the fetch rules.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_W  = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        branch;
    logic [31:0] branchPCo;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;

    instr_fetch_unit #(.RESET_PC(RST_PC), .NOP(NOP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .branch     (branch),
        .branchPCo  (branchPCo),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc4     (if_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: started / squashing / holding flags plus IF/ID image.
    logic [31:0] m_pc, m_redir, m_hword, m_instr, m_pc4;
    logic        m_started, m_squash, m_held, m_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_redir = '0; m_hword = '0; m_instr = NOP_W; m_pc4 = '0;
        m_started = 1'b0; m_squash = 1'b0; m_held = 1'b0; m_v = 1'b0;
    endtask

    task automatic model_step(input logic b, input logic [31:0] t_raw, input logic st,
                              input logic rdy, input logic [31:0] rd);
        logic [31:0] t;
        t = t_raw & 32'hFFFF_FFFC;
        if (!m_started) begin
            if (b) m_pc = t;
            m_started = 1'b1;
        end else if (m_held) begin
            if (b) begin
                m_held = 1'b0; m_pc = t; m_v = 1'b0;
            end else if (!st) begin
                m_held = 1'b0; m_v = 1'b1; m_instr = m_hword;
                m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
            end
        end else if (m_squash) begin
            if (b) m_redir = t;
            if (rdy) begin
                m_pc = m_redir; m_squash = 1'b0;
            end
        end else if (b) begin
            m_v = 1'b0;
            if (rdy) m_pc = t;
            else begin
                m_squash = 1'b1; m_redir = t;
            end
        end else if (rdy) begin
            if (!st) begin
                m_v = 1'b1; m_instr = rd; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
            end else begin
                m_held = 1'b1; m_hword = rd;
            end
        end else if (!st) begin
            m_v = 1'b0;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.req   = m_started && !m_held;
        e.pc    = m_pc;
        e.valid = m_v;
        e.instr = m_instr;
        e.pc4   = m_pc4;
        return e;
    endfunction

    // One clock: drive at negedge, predict, return just after the edge.
    task automatic step(input logic b, input logic [31:0] t, input logic st,
                        input logic rdy, input logic [31:0] rd);
        @(negedge clk);
        branch = b; branchPCo = t; stall = st; imem_ready = rdy; imem_rdata = rd;
        model_step(b, t, st, rdy, rd);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares DUT state with the oldest prediction after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_imem_req",  32'(imem_req), 32'(e.req));
                chk("sb_imem_addr", imem_addr,     e.pc);
                chk("sb_pc",        pc,            e.pc);
                chk("sb_if_valid",  32'(if_valid), 32'(e.valid));
                if (e.valid) begin
                    chk("sb_if_instr", if_instr, e.instr);
                    chk("sb_if_pc4",   if_pc4,   e.pc4);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic rand_steps(input int n);
        logic        b, st, rdy;
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            b   = ($urandom_range(0, 9) == 0);
            st  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            t   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step(b, t, st, rdy, $urandom);
        end
    endtask

    initial begin
        rst_n = 1'b0; branch = 1'b0; branchPCo = '0; stall = 1'b0;
        imem_ready = 1'b0; imem_rdata = '0;
        model_reset();
        #23;
        chk("rst_pc",       pc,              RST_PC);
        chk("rst_imem_req", 32'(imem_req),   32'd0);
        chk("rst_if_valid", 32'(if_valid),   32'd0);
        chk("rst_if_instr", if_instr,        NOP_W);
        chk("rst_if_pc4",   if_pc4,          32'd0);
        @(posedge clk); #2; rst_n = 1'b1;

        // Zero-wait streaming from reset.
        step(1'b0, '0, 1'b0, 1'b1, 32'h1111_0000);
        chk("first_fetch_addr", imem_addr, 32'h0);
        chk("first_fetch_req",  32'(imem_req), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1, 32'h1111_0001);
        chk("stream_pc4_4",  if_pc4, 32'd4);
        chk("stream_valid1", 32'(if_valid), 32'd1);
        chk("stream_instr1", if_instr, 32'h1111_0001);
        step(1'b0, '0, 1'b0, 1'b1, 32'h1111_0002);
        chk("stream_pc4_8", if_pc4, 32'd8);
        step(1'b0, '0, 1'b0, 1'b1, 32'h1111_0003);
        chk("stream_pc4_12",  if_pc4, 32'd12);
        chk("stream_valid3",  32'(if_valid), 32'd1);

        // Redirect with ready: target aligned, IF/ID killed.
        step(1'b1, 32'h0000_0103, 1'b0, 1'b1, 32'hAAAA_0000);
        chk("redir_pc",    pc, 32'h0000_0100);
        chk("redir_valid", 32'(if_valid), 32'd0);

        // Redirect during an un-ready request.
        step(1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'hBAD0_0001);
        chk("discard_addr1", imem_addr, 32'h100);
        step(1'b0, '0, 1'b0, 1'b0, 32'hBAD0_0002);
        chk("discard_addr2", imem_addr, 32'h100);
        step(1'b0, '0, 1'b0, 1'b0, 32'hBAD0_0003);
        chk("discard_addr3", imem_addr, 32'h100);
        chk("discard_req",   32'(imem_req), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1, 32'hBAD0_BAD0);
        chk("discard_next_addr", imem_addr, 32'h200);
        chk("discard_valid",     32'(if_valid), 32'd0);

        // Stall when a word returns: skid buffer, then release.
        step(1'b0, '0, 1'b0, 1'b1, 32'h2222_0000);
        chk("pre_hold_instr", if_instr, 32'h2222_0000);
        step(1'b0, '0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        chk("hold_req",   32'(imem_req), 32'd0);
        chk("hold_instr", if_instr, 32'h2222_0000);
        chk("hold_valid", 32'(if_valid), 32'd1);
        step(1'b0, '0, 1'b1, 1'b1, 32'h5555_5555);
        chk("hold2_instr", if_instr, 32'h2222_0000);
        step(1'b0, '0, 1'b0, 1'b0, 32'h6666_6666);
        chk("unhold_instr", if_instr, 32'hDEAD_BEEF);
        chk("unhold_valid", 32'(if_valid), 32'd1);
        chk("unhold_pc4",   if_pc4, 32'h208);
        chk("unhold_req",   32'(imem_req), 32'd1);

        // Branch together with stall while holding.
        step(1'b0, '0, 1'b1, 1'b1, 32'h3333_0000);
        step(1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h7777_7777);
        chk("hold_br_pc",    pc, 32'h300);
        chk("hold_br_valid", 32'(if_valid), 32'd0);
        step(1'b0, '0, 1'b0, 1'b1, 32'h8888_0000);
        chk("hold_br_instr", if_instr, 32'h8888_0000);

        // PC wrap at the top of the address space.
        step(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'h0);
        chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
        step(1'b0, '0, 1'b0, 1'b1, 32'h4444_0000);
        chk("wrap_pc4", if_pc4, 32'h0);
        chk("wrap_pc",  pc, 32'h0);

        rand_steps(3000);

        // Asynchronous reset in the middle of a fetch.
        step(1'b0, '0, 1'b0, 1'b0, 32'h0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc",    pc, RST_PC);
        chk("async_rst_req",   32'(imem_req), 32'd0);
        chk("async_rst_valid", 32'(if_valid), 32'd0);
        chk("async_rst_instr", if_instr, NOP_W);
        model_reset();
        @(posedge clk); #2; rst_n = 1'b1;

        rand_steps(500);

        @(posedge clk); #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch stage sitting on the consumer side of the branch/jump decision logic. It owns the program counter, applies `branch`/`branchPCo` redirects, drives a ready-handshaked instruction memory port, and fills the IF/ID pipeline register. It honours back-pressure from the hazard unit through `stall` and a one-entry skid buffer, and discards in-flight fetches made stale by a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP`, default 32'h0000_0000: value of `if_instr` at reset.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `branch` in 1: redirect request, valid in the same cycle as `branchPCo`.
- `branchPCo` in 32: redirect target; bits [1:0] are ignored and treated as 0.
- `stall` in 1: IF/ID must hold its contents this cycle.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, always equal to `pc`.
- `imem_ready` in 1: `imem_rdata` is valid and the request completes this cycle.
- `imem_rdata` in 32: fetched word.
- `pc` out 32: current fetch PC.
- `if_valid` out 1: IF/ID holds a live instruction.
- `if_instr` out 32: IF/ID instruction.
- `if_pc4` out 32: IF/ID PC+4 of that instruction.

## Operation
- Reset values: `pc`=RESET_PC, state IDLE, `imem_req`=0, `if_valid`=0, `if_instr`=NOP, `if_pc4`=0, skid buffer empty.
- `imem_req`=1 in FETCH and DISCARD, and 0 in IDLE and HOLD. `imem_addr` must not change while `imem_req`=1 and `imem_ready`=0.
- The PC increments by 4 and wraps modulo 2^32. A redirect target is loaded as {branchPCo[31:2],2'b00}.
- `branch` overrides `stall`. Any redirect clears `if_valid` at the next edge, even if `stall`=1.

States:
- **IDLE**: lasts one cycle after reset release, then moves to FETCH. If `branch`=1, `pc` is set to the target.
- **FETCH**, checked in priority order:
  - `branch`=1 and `imem_ready`=1: drop the data, set `pc` to the target, stay in FETCH.
  - `branch`=1 and `imem_ready`=0: store the target in `redir_pc` and move to DISCARD.
  - `imem_ready`=1 and `stall`=0: load `if_instr`=rdata, `if_pc4`=pc+4, `if_valid`=1; set `pc`=pc+4.
  - `imem_ready`=1 and `stall`=1: capture rdata in the skid buffer and move to HOLD. IF/ID holds.
  - `imem_ready`=0 and `stall`=0: `if_valid` goes to 0 (bubble).
  - `imem_ready`=0 and `stall`=1: IF/ID holds.
- **DISCARD**: the request stays at the old address. Another `branch` overwrites `redir_pc` (latest wins). On `imem_ready`: drop the data, set `pc`=redir_pc, move to FETCH. `if_valid` is 0.
- **HOLD**:
  - `branch`=1: empty the skid buffer, set `pc` to the target, move to FETCH.
  - `stall`=0: load IF/ID from the skid buffer, set `pc`=pc+4, move to FETCH.
  - Otherwise stay in HOLD.
- Asserting `rst_n` mid-transaction returns everything to reset values immediately. The outstanding memory response is not tracked.

## Timing
- Zero-wait memory (`imem_ready`=1) with `stall`=0 gives one instruction per cycle. A word fetched at edge N is in IF/ID after edge N.
- Redirect in FETCH with ready: `imem_addr` equals the target in cycle N+1. The first target instruction is valid after edge N+1.
- Redirect with an outstanding un-ready request: the target is issued in the cycle after `imem_ready` arrives in DISCARD.
- The HOLD exit issues the next fetch in the cycle after `stall` falls.
- All outputs are registered or decoded from state/`pc` only. There is no combinational path from inputs to `imem_req` or `imem_addr`.

## Structure
- Shared package `pipe_pkg`:
  - state enum {IDLE, FETCH, DISCARD, HOLD}
  - NOP and default RESET_PC constants
  - `INSTR_W`=32
- One sub-module, `fetch_skid_reg`: a one-entry 32-bit buffer with load, clear and valid signals.

## Test plan
- Reset release with ready always 1 and RESET_PC=0: `imem_addr` is 0 in the first FETCH cycle. `if_pc4` reads 4, 8, 12 on consecutive cycles, with `if_valid`=1 continuously.
- `branch`=1 with `branchPCo`=32'h0000_0103 while ready: `pc` becomes 32'h0000_0100 next cycle, and `if_valid`=0 for that cycle.
- Ready low for 3 cycles, `branch` to 0x200 in cycle 1: `imem_addr` stays at the old PC until ready, the returned word never reaches IF/ID, and the next address is 0x200.
- `stall`=1 when a word returns (rdata=32'hDEAD_BEEF): `imem_req`=0 and IF/ID is unchanged. When `stall` drops, `if_instr`=32'hDEADBEEF and `if_valid`=1 on the next edge.
- `branch` and `stall` together in HOLD: the skid word is discarded, `if_valid`=0, and `pc` equals the target.
- `pc`=32'hFFFF_FFFC fetch completes: `if_pc4`=0 and `pc` wraps to 0. Pulsing `rst_n` low mid-fetch restores `pc`=RESET_PC and `imem_req`=0 asynchronously.
